fetch_ctrl: RTL and testbench

Sequencing controller for the fetch stage: owns the fetch PC and decides, every cycle, whether the FE/DE latch issues the next sequential instruction, redirects to a resolved branch target, holds, or injects a bubble. It arbitrates between the decode-stage stall signals, the memory-stage branch redirect and the frame stall, so the instruction-memory read path only sees an address and an enable. It also keeps saturating stall-cycle counters and a sticky branch-resolution timeout flag for debug.

---
 rtl/fetch_ctrl_pkg.sv | 17 +
 rtl/fetch_ctrl_sat_counter.sv | 23 ++
 rtl/fetch_ctrl.sv | 145 ++++++++++++++
 tb/tb_fetch_ctrl.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/fetch_ctrl_pkg.sv
// Shared definitions for the fetch sequencing controller: state encoding
// and fetch-address constants.
package fetch_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_RUN    = 3'd1,
    ST_DEP    = 3'd2,
    ST_BRWAIT = 3'd3,
    ST_FRAME  = 3'd4
  } state_t;

  localparam int PC_INC  = 4;
  // Wide enough for the largest legal branch-wait timeout (255).
  localparam int TIMER_W = 8;

endpackage

// File: rtl/fetch_ctrl_sat_counter.sv
// Saturating up-counter clocked on the falling edge, with synchronous clear
// and asynchronous active-high reset.
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  always_ff @(negedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/fetch_ctrl.sv
// Fetch-stage sequencer: owns the fetch PC and chooses issue, redirect,
// hold or bubble every falling edge, plus debug stall statistics.
module fetch_ctrl
  import fetch_ctrl_pkg::*;
#(
  parameter int PC_WIDTH   = 16,
  parameter int CNT_WIDTH  = 16,
  parameter int BR_TIMEOUT = 7
) (
  input  logic                 I_CLOCK,
  input  logic                 I_RESET,
  input  logic                 I_LOCK,
  input  logic                 I_BranchStallSignal,
  input  logic                 I_DepStallSignal,
  input  logic                 I_FRAMESTALL,
  input  logic                 I_BranchAddrSelect,
  input  logic [PC_WIDTH-1:0]  I_BranchPC,
  output logic                 O_LOCK,
  output logic                 O_FetchEn,
  output logic [PC_WIDTH-1:0]  O_FetchAddr,
  output logic [PC_WIDTH-1:0]  O_NextPC,
  output logic                 O_FetchStall,
  output logic [2:0]           O_State,
  output logic                 O_BrTimeout,
  output logic [CNT_WIDTH-1:0] O_BubbleCnt,
  output logic [CNT_WIDTH-1:0] O_DepCnt
);

  state_t              state_q, state_d;
  logic [PC_WIDTH-1:0] pc_q, pc_d, addr_d, next_d;
  logic [PC_WIDTH-1:0] target, pc_plus;
  logic                en_d, stall_d, timeout_d;
  logic                timer_inc, timer_clr, bub_inc, dep_inc;
  logic [TIMER_W-1:0]  timer;

  // Branch targets are word aligned; the low address bits are discarded.
  assign target  = {I_BranchPC[PC_WIDTH-1:2], 2'b00};
  assign pc_plus = pc_q + PC_WIDTH'(PC_INC);

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    addr_d    = O_FetchAddr;
    next_d    = O_NextPC;
    en_d      = 1'b0;
    stall_d   = O_FetchStall;
    timeout_d = O_BrTimeout;
    timer_inc = 1'b0;
    timer_clr = 1'b0;
    bub_inc   = 1'b0;
    dep_inc   = 1'b0;
    if (!I_LOCK) begin
      state_d   = ST_IDLE;
      pc_d      = '0;
      addr_d    = '0;
      next_d    = '0;
      en_d      = 1'b1;
      stall_d   = 1'b0;
      timer_clr = 1'b1;
    end else if (I_BranchAddrSelect) begin
      state_d   = ST_RUN;
      addr_d    = target;
      next_d    = target + PC_WIDTH'(PC_INC);
      pc_d      = target + PC_WIDTH'(PC_INC);
      en_d      = 1'b1;
      stall_d   = 1'b0;
      timer_clr = 1'b1;
    end else if (I_FRAMESTALL) begin
      state_d = ST_FRAME;
    end else if (I_BranchStallSignal && !I_DepStallSignal) begin
      state_d   = ST_BRWAIT;
      addr_d    = pc_q;
      next_d    = pc_plus;
      stall_d   = 1'b1;
      timer_inc = 1'b1;
      bub_inc   = 1'b1;
      // The flag rises on the edge that brings the timer up to the limit.
      if ((int'(timer) + 1) >= BR_TIMEOUT) begin
        timeout_d = 1'b1;
      end
    end else if (I_DepStallSignal) begin
      state_d = ST_DEP;
      addr_d  = pc_q;
      next_d  = pc_plus;
      stall_d = 1'b0;
      dep_inc = 1'b1;
    end else begin
      state_d = ST_RUN;
      addr_d  = pc_q;
      next_d  = pc_plus;
      pc_d    = pc_plus;
      en_d    = 1'b1;
      stall_d = 1'b0;
    end
  end

  always_ff @(negedge I_CLOCK or posedge I_RESET) begin
    if (I_RESET) begin
      state_q      <= ST_IDLE;
      pc_q         <= '0;
      O_FetchAddr  <= '0;
      O_NextPC     <= '0;
      O_FetchEn    <= 1'b0;
      O_FetchStall <= 1'b0;
      O_BrTimeout  <= 1'b0;
      O_LOCK       <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      O_FetchAddr  <= addr_d;
      O_NextPC     <= next_d;
      O_FetchEn    <= en_d;
      O_FetchStall <= stall_d;
      O_BrTimeout  <= timeout_d;
      O_LOCK       <= I_LOCK;
    end
  end

  assign O_State = state_q;

  sat_counter #(.WIDTH(CNT_WIDTH)) u_bubble_cnt (
    .clk  (I_CLOCK),
    .rst  (I_RESET),
    .clear(1'b0),
    .inc  (bub_inc),
    .count(O_BubbleCnt)
  );

  sat_counter #(.WIDTH(CNT_WIDTH)) u_dep_cnt (
    .clk  (I_CLOCK),
    .rst  (I_RESET),
    .clear(1'b0),
    .inc  (dep_inc),
    .count(O_DepCnt)
  );

  sat_counter #(.WIDTH(TIMER_W)) u_br_timer (
    .clk  (I_CLOCK),
    .rst  (I_RESET),
    .clear(timer_clr),
    .inc  (timer_inc),
    .count(timer)
  );

endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: directed scenarios plus randomized traffic, checked
// against a behavioural model of the fetch sequencing rules.
module tb_fetch_ctrl;

  localparam int PC_W    = 16;
  localparam int CNT_W   = 4;
  localparam int BRT     = 7;
  localparam int PC_MASK = (1 << PC_W) - 1;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic            clk = 1'b0;
  logic            rst, lock, bsel, frame, bstall, dep;
  logic [PC_W-1:0] bpc;
  logic            o_lock, o_en, o_stall, o_to;
  logic [PC_W-1:0] o_addr, o_next;
  logic [2:0]      o_state;
  logic [CNT_W-1:0] o_bub, o_dep;

  int checks   = 0;
  int failures = 0;

  // Model state: what the DUT outputs should show after the next falling edge.
  int m_state, m_pc, m_addr, m_next, m_en, m_stall, m_to, m_bub, m_dep, m_timer, m_lock;

  fetch_ctrl #(.PC_WIDTH(PC_W), .CNT_WIDTH(CNT_W), .BR_TIMEOUT(BRT)) dut (
    .I_CLOCK            (clk),
    .I_RESET            (rst),
    .I_LOCK             (lock),
    .I_BranchStallSignal(bstall),
    .I_DepStallSignal   (dep),
    .I_FRAMESTALL       (frame),
    .I_BranchAddrSelect (bsel),
    .I_BranchPC         (bpc),
    .O_LOCK             (o_lock),
    .O_FetchEn          (o_en),
    .O_FetchAddr        (o_addr),
    .O_NextPC           (o_next),
    .O_FetchStall       (o_stall),
    .O_State            (o_state),
    .O_BrTimeout        (o_to),
    .O_BubbleCnt        (o_bub),
    .O_DepCnt           (o_dep)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_state = 0; m_pc = 0; m_addr = 0; m_next = 0; m_en = 0; m_stall = 0;
    m_to = 0; m_bub = 0; m_dep = 0; m_timer = 0; m_lock = 0;
  endtask

  task automatic model_step();
    int tgt;
    if (!lock) begin
      m_state = 0; m_pc = 0; m_addr = 0; m_next = 0; m_en = 1; m_stall = 0; m_timer = 0;
    end else if (bsel) begin
      tgt = int'(bpc) & ~3;
      m_state = 1; m_addr = tgt; m_next = (tgt + 4) & PC_MASK; m_pc = m_next;
      m_en = 1; m_stall = 0; m_timer = 0;
    end else if (frame) begin
      m_state = 4; m_en = 0;
    end else if (bstall && !dep) begin
      m_state = 3; m_en = 0; m_stall = 1;
      m_addr = m_pc; m_next = (m_pc + 4) & PC_MASK;
      if (m_timer < 255) m_timer++;
      if (m_timer >= BRT) m_to = 1;
      if (m_bub < CNT_MAX) m_bub++;
    end else if (dep) begin
      m_state = 2; m_en = 0; m_stall = 0;
      m_addr = m_pc; m_next = (m_pc + 4) & PC_MASK;
      if (m_dep < CNT_MAX) m_dep++;
    end else begin
      m_state = 1; m_addr = m_pc; m_next = (m_pc + 4) & PC_MASK; m_pc = m_next;
      m_en = 1; m_stall = 0;
    end
    m_lock = int'(lock);
  endtask

  task automatic check_all();
    check("state",   32'(o_state), m_state);
    check("fetch_en", 32'(o_en),   m_en);
    check("addr",    32'(o_addr),  m_addr);
    check("next_pc", 32'(o_next),  m_next);
    check("stall",   32'(o_stall), m_stall);
    check("timeout", 32'(o_to),    m_to);
    check("bub_cnt", 32'(o_bub),   m_bub);
    check("dep_cnt", 32'(o_dep),   m_dep);
    check("lock_d",  32'(o_lock),  m_lock);
  endtask

  // Drive inputs just after a rising edge; the DUT samples on the falling
  // edge and the outputs are compared on the following rising edge.
  task automatic cycle(input logic l, input logic bs, input int pc,
                       input logic fr, input logic st, input logic dp);
    lock = l; bsel = bs; bpc = PC_W'(pc); frame = fr; bstall = st; dep = dp;
    model_step();
    @(posedge clk);
    check_all();
  endtask

  task automatic do_reset();
    rst = 1'b1; lock = 0; bsel = 0; bpc = '0; frame = 0; bstall = 0; dep = 0;
    model_reset();
    repeat (2) @(posedge clk);
    rst = 1'b0;
    check_all();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    do_reset();
    check("rst_en", 32'(o_en), 0);

    // Idle then sequential issue from address 0.
    cycle(0, 0, 0, 0, 0, 0);
    check("idle_en", 32'(o_en), 1);
    for (int i = 0; i < 4; i++) begin
      cycle(1, 0, 0, 0, 0, 0);
      check("seq_addr", 32'(o_addr), 32'(i * 4));
    end

    // Dependency stall holds at 0x10 for three edges.
    for (int i = 0; i < 3; i++) cycle(1, 0, 0, 0, 0, 1);
    check("dep_en", 32'(o_en), 0);
    check("dep_addr", 32'(o_addr), 32'h10);
    check("dep_cnt3", 32'(o_dep), 3);
    cycle(1, 0, 0, 0, 0, 0);
    check("dep_resume", 32'(o_addr), 32'h10);

    // Branch stall bubbles then redirect to 0x40.
    do_reset();
    cycle(0, 0, 0, 0, 0, 0);
    cycle(1, 0, 0, 0, 0, 0);
    cycle(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      cycle(1, 0, 0, 0, 1, 0);
      check("bubble", 32'(o_stall), 1);
    end
    cycle(1, 1, 32'h40, 0, 1, 0);
    check("redir_addr", 32'(o_addr), 32'h40);
    check("redir_next", 32'(o_next), 32'h44);
    check("bub_cnt4", 32'(o_bub), 4);
    cycle(1, 0, 0, 0, 0, 0);
    check("after_redir", 32'(o_addr), 32'h44);

    // Branch-wait timeout becomes sticky.
    do_reset();
    cycle(0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 10; i++) begin
      cycle(1, 0, 0, 0, 1, 0);
      if (i == 5) check("to_before", 32'(o_to), 0);
      if (i == 6) check("to_at7", 32'(o_to), 1);
    end
    cycle(1, 1, 32'h43, 0, 0, 0);
    check("to_sticky", 32'(o_to), 1);
    check("lowbits", 32'(o_addr), 32'h40);

    // Redirect wins over frame stall, then fetch freezes.
    cycle(1, 1, 32'h80, 1, 0, 0);
    check("frm_redir", 32'(o_addr), 32'h80);
    for (int i = 0; i < 3; i++) begin
      cycle(1, 0, 0, 1, 1, 1);
      check("frm_addr", 32'(o_addr), 32'h80);
      check("frm_next", 32'(o_next), 32'h84);
    end
    cycle(1, 0, 0, 0, 0, 0);
    check("frm_resume", 32'(o_addr), 32'h84);

    // PC wraps at the top of the address space.
    cycle(1, 1, 32'hFFFC, 0, 0, 0);
    check("wrap_next", 32'(o_next), 0);
    cycle(1, 0, 0, 0, 0, 0);
    check("wrap_addr", 32'(o_addr), 0);

    // Asynchronous reset between edges during a branch wait.
    for (int i = 0; i < 3; i++) cycle(1, 0, 0, 0, 1, 0);
    #2 rst = 1'b1;
    #1;
    model_reset();
    check("arst_state", 32'(o_state), 0);
    check("arst_to", 32'(o_to), 0);
    check("arst_bub", 32'(o_bub), 0);
    check_all();
    rst = 1'b0;

    // Randomized traffic.
    for (int i = 0; i < 600; i++) begin
      cycle($urandom_range(0, 99) < 95, $urandom_range(0, 99) < 12, int'($urandom_range(0, PC_MASK)),
            $urandom_range(0, 99) < 15, $urandom_range(0, 99) < 40, $urandom_range(0, 99) < 30);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
